multi_channel_function_generator: RTL

- Parametrised N-channel successor of the single-channel function generator.
- Each channel has a phase-accumulator (DDS) frequency source, a 6-mode waveform shaper, a multiplicative amplitude gain and a PWM output; all channels share one PWM period counter.
- Channels are configured at runtime through a register-write port. Writes go to shadow registers and apply only at PWM period boundaries, so outputs never glitch.
- Sits between the board switch/control logic and the RC-filtered analog pins.

---
 rtl/multi_channel_function_generator.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/multi_channel_function_generator.sv
// multi_channel_function_generator
// N-channel DDS function generator: per-channel phase accumulator, six-mode
// waveform shaper, multiplicative gain and PWM output, all channels sharing one
// PWM period counter. Runtime configuration lands in shadow registers and is
// copied to the active set only at the period boundary, so outputs never glitch.
// Optional build macro: FGEN_PHASE_SYNC_EN adds the active-low synchronous
// sync_n input that zeroes every phase accumulator and the period counter.
module multi_channel_function_generator #(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 8,
    parameter int PHASE_W  = 16,
    parameter int AMP_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
`ifdef FGEN_PHASE_SYNC_EN
    input  logic                sync_n,
`endif
    input  logic                cfg_we,
    input  logic [2:0]          cfg_chan,
    input  logic [1:0]          cfg_addr,
    input  logic [PHASE_W-1:0]  cfg_data,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_strobe
);

    localparam logic [DATA_W-1:0] FULL = {DATA_W{1'b1}};
    localparam logic [15:0]       LFSR_SEED = 16'hACE1;

    logic [DATA_W-1:0]  r_cnt;
    logic               r_strobe;
    logic               w_boundary;
    logic               w_sync;

    logic [PHASE_W-1:0] r_tw_sh   [CHANNELS];
    logic [2:0]         r_wave_sh [CHANNELS];
    logic [AMP_W-1:0]   r_amp_sh  [CHANNELS];
    logic               r_en_sh   [CHANNELS];

    logic [PHASE_W-1:0] r_tw_act   [CHANNELS];
    logic [2:0]         r_wave_act [CHANNELS];
    logic [AMP_W-1:0]   r_amp_act  [CHANNELS];
    logic               r_en_act   [CHANNELS];

    logic [PHASE_W-1:0] r_phase [CHANNELS];
    logic [DATA_W-1:0]  r_duty  [CHANNELS];
    logic [15:0]        r_lfsr  [CHANNELS];
    logic [CHANNELS-1:0] r_pwm;

    // Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, shifting towards the LSB.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    // Waveform shaper; p is the top DATA_W bits of the phase accumulator.
    function automatic logic [DATA_W-1:0] shape(input logic [2:0]        wave,
                                                input logic [DATA_W-1:0] p,
                                                input logic [15:0]       l);
        logic [DATA_W-1:0] t;
        logic [DATA_W-1:0] n;
        t = {p[DATA_W-2:0], 1'b0};
        n = '0;
        for (int i = 0; i < DATA_W; i++)
            n[i] = (i < 16) ? l[i % 16] : 1'b0;
        case (wave)
            3'd1:    return p[DATA_W-1] ? '0 : FULL;
            3'd2:    return p;
            3'd3:    return FULL - p;
            3'd4:    return p[DATA_W-1] ? ~t : t;
            3'd5:    return n;
            default: return '0;
        endcase
    endfunction

    // Truncating gain; an all-ones amplitude is an exact pass-through.
    function automatic logic [DATA_W-1:0] gain(input logic [DATA_W-1:0] s,
                                               input logic [AMP_W-1:0]  a);
        logic [DATA_W+AMP_W-1:0] prod;
        prod = {{AMP_W{1'b0}}, s} * {{DATA_W{1'b0}}, a};
        if (&a)
            return s;
        return prod[AMP_W +: DATA_W];
    endfunction

`ifdef FGEN_PHASE_SYNC_EN
    assign w_sync = ~sync_n;
`else
    assign w_sync = 1'b0;
`endif

    assign w_boundary    = (r_cnt == FULL);
    assign pwm_out       = r_pwm;
    assign period_strobe = r_strobe;

    // Shared period counter and registered boundary strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= w_boundary;
            r_cnt    <= w_sync ? '0 : r_cnt + DATA_W'(1);
        end
    end

    // Shadow register writes; channel indices beyond CHANNELS match nothing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_tw_sh[c]   <= '0;
                r_wave_sh[c] <= '0;
                r_amp_sh[c]  <= '1;
                r_en_sh[c]   <= 1'b0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (cfg_we && cfg_chan == 3'(c)) begin
                    case (cfg_addr)
                        2'd0: r_tw_sh[c]   <= cfg_data;
                        2'd1: r_wave_sh[c] <= cfg_data[2:0];
                        2'd2: r_amp_sh[c]  <= cfg_data[AMP_W-1:0];
                        2'd3: r_en_sh[c]   <= cfg_data[0];
                    endcase
                end
            end
        end
    end

    // Boundary update: duty from the pre-copy active config, phase step, LFSR
    // step and shadow-to-active copy all happen on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_tw_act[c]   <= '0;
                r_wave_act[c] <= '0;
                r_amp_act[c]  <= '1;
                r_en_act[c]   <= 1'b0;
                r_phase[c]    <= '0;
                r_duty[c]     <= '0;
                r_lfsr[c]     <= LFSR_SEED;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_boundary) begin
                    r_duty[c]     <= r_en_act[c]
                                   ? gain(shape(r_wave_act[c], r_phase[c][PHASE_W-1 -: DATA_W], r_lfsr[c]),
                                          r_amp_act[c])
                                   : '0;
                    r_phase[c]    <= r_en_act[c] ? r_phase[c] + r_tw_act[c] : '0;
                    r_lfsr[c]     <= lfsr_step(r_lfsr[c]);
                    r_tw_act[c]   <= r_tw_sh[c];
                    r_wave_act[c] <= r_wave_sh[c];
                    r_amp_act[c]  <= r_amp_sh[c];
                    r_en_act[c]   <= r_en_sh[c];
                end
                if (w_sync)
                    r_phase[c] <= '0;
            end
        end
    end

    // Registered PWM comparators, one cycle behind the counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pwm <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++)
                r_pwm[c] <= (r_cnt < r_duty[c]);
        end
    end

endmodule
